// File: rtl/emissor_data_pkg.sv
// Shared constants for the two-word instruction link (transmitter and receiver).
package emissor_data_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSendA,
        StSendB,
        StGap
    } state_e;

    localparam int unsigned STROBE_A_BIT = 18;
    localparam int unsigned STROBE_B_BIT = 30;
    localparam int unsigned A_WIDTH      = 18;
    localparam int unsigned B_WIDTH      = 32;
    localparam int unsigned LINK_WIDTH   = 32;
    localparam int unsigned PAIR_WIDTH   = A_WIDTH + B_WIDTH;

    // Link word A: zero-extended payload with the A strobe raised.
    function automatic logic [LINK_WIDTH-1:0] link_word_a(input logic [A_WIDTH-1:0] a);
        logic [LINK_WIDTH-1:0] w;
        w               = '0;
        w[A_WIDTH-1:0]  = a;
        w[STROBE_A_BIT] = 1'b1;
        return w;
    endfunction

    // Link word B: caller's bit 30 is replaced by the B strobe.
    function automatic logic [LINK_WIDTH-1:0] link_word_b(input logic [B_WIDTH-1:0] b);
        logic [LINK_WIDTH-1:0] w;
        w               = b;
        w[STROBE_B_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/emissor_fifo.sv
// Synchronous FIFO holding instruction pairs; DEPTH must be a power of two.
module emissor_fifo #(
    parameter int unsigned WIDTH = 50,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;

    assign rdata = mem_q[rptr_q];
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks push/pop balance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/emissor_data.sv
// Link transmitter: buffers instruction pairs and serialises them as A, B, then an idle gap.
module emissor_data
    import emissor_data_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 2,
    localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [A_WIDTH-1:0]    in_a,
    input  logic [B_WIDTH-1:0]    in_b,
    output logic [LINK_WIDTH-1:0] out_dataA,
    output logic [LINK_WIDTH-1:0] out_dataB,
    output logic                  busy,
    output logic [LW-1:0]         level
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    state_e                  state_q;
    logic [GW-1:0]           gap_cnt_q;
    logic [A_WIDTH-1:0]      hold_a_q;
    logic [B_WIDTH-1:0]      hold_b_q;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [PAIR_WIDTH-1:0]   fifo_rdata;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // Pop from IDLE, or straight out of the last gap cycle for back-to-back issue.
    assign pop      = !fifo_empty &&
                      ((state_q == StIdle) || ((state_q == StGap) && (gap_cnt_q == '0)));
    assign busy     = !fifo_empty || (state_q != StIdle);

    emissor_fifo #(
        .WIDTH (PAIR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({in_a, in_b}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // FSM with registered link outputs; each state's word appears on the cycle after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            out_dataA <= '0;
            out_dataB <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    out_dataA <= '0;
                    out_dataB <= '0;
                    if (pop) begin
                        hold_a_q <= fifo_rdata[PAIR_WIDTH-1:B_WIDTH];
                        hold_b_q <= fifo_rdata[B_WIDTH-1:0];
                        state_q  <= StSendA;
                    end
                end
                StSendA: begin
                    out_dataA <= link_word_a(hold_a_q);
                    out_dataB <= '0;
                    state_q   <= StSendB;
                end
                StSendB: begin
                    out_dataA <= '0;
                    out_dataB <= link_word_b(hold_b_q);
                    gap_cnt_q <= GW'(GAP_CYCLES - 1);
                    state_q   <= StGap;
                end
                StGap: begin
                    out_dataA <= '0;
                    out_dataB <= '0;
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end else if (pop) begin
                        hold_a_q <= fifo_rdata[PAIR_WIDTH-1:B_WIDTH];
                        hold_b_q <= fifo_rdata[B_WIDTH-1:0];
                        state_q  <= StSendA;
                    end else begin
                        state_q  <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emissor_data.sv
// Randomised bench for emissor_data against a timing-level reference model.
module tb_emissor_data;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 2;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [17:0]   in_a;
    logic [31:0]   in_b;
    logic [31:0]   out_dataA;
    logic [31:0]   out_dataB;
    logic          busy;
    logic [LW-1:0] level;

    emissor_data #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_dataA (out_dataA),
        .out_dataB (out_dataB),
        .busy      (busy),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each pair is issued at max(push+1, previous issue + 2 + GAP);
    // word A shows one edge after issue, word B two edges after.
    int          cyc;
    int          next_free;
    int          last_pop;
    int          m_level;
    logic [31:0] exp_a  [int];
    logic [31:0] exp_b  [int];
    bit          pop_at [int];
    bit          prev_sa;

    function automatic void model_reset();
        cyc       = 0;
        next_free = 0;
        last_pop  = -1000;
        m_level   = 0;
        exp_a.delete();
        exp_b.delete();
        pop_at.delete();
        prev_sa   = 1'b0;
    endfunction

    function automatic void record_push(input logic [17:0] a, input logic [31:0] b);
        int          p;
        logic [31:0] wb;
        p         = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        next_free = p + 2 + int'(GAP);
        pop_at[p] = 1'b1;
        exp_a[p + 1] = {13'd0, 1'b1, a};
        wb        = b;
        wb[30]    = 1'b1;
        exp_b[p + 2] = wb;
        m_level++;
    endfunction

    task automatic check_cycle();
        logic [31:0] ea;
        logic [31:0] eb;
        bit          eb_busy;
        ea      = exp_a.exists(cyc) ? exp_a[cyc] : 32'd0;
        eb      = exp_b.exists(cyc) ? exp_b[cyc] : 32'd0;
        eb_busy = (m_level > 0) || (cyc < last_pop + 2 + int'(GAP));
        check("dataA", out_dataA, ea);
        check("dataB", out_dataB, eb);
        check("level", 32'(level), 32'(m_level));
        check("in_ready", 32'(in_ready), 32'(m_level != int'(DEPTH)));
        check("busy", 32'(busy), 32'(eb_busy));
        check("strobe_excl", 32'(out_dataA[18] & out_dataB[30]), 32'd0);
        check("strobeA_twice", 32'(prev_sa & out_dataA[18]), 32'd0);
        prev_sa = out_dataA[18];
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic run_cycle(input bit v, input logic [17:0] a, input logic [31:0] b,
                             output bit pushed);
        bit rdy;
        rdy      = (m_level != int'(DEPTH));
        in_valid = v;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        cyc++;
        pushed = v && rdy;
        if (pushed) record_push(a, b);
        if (pop_at.exists(cyc)) begin
            m_level--;
            last_pop = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_cycle();
    endtask

    task automatic idle_cycles(input int n);
        bit dummy;
        for (int i = 0; i < n; i++) run_cycle(1'b0, 18'd0, 32'd0, dummy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pushed;
        int          n0;
        int          k;
        int          sa_times[$];
        bit          saw_not_ready;
        logic [17:0] fa [6];
        logic [31:0] fb [6];

        reset    = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        model_reset();

        // Reset then idle
        repeat (3) @(negedge clk);
        check("rst_dataA", out_dataA, 32'd0);
        check("rst_dataB", out_dataB, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        reset = 1'b0;
        model_reset();
        idle_cycles(5);

        // Single pair with fixed expectations
        run_cycle(1'b1, 18'h2ABCD, 32'hC0000005, pushed);
        check("single_accept", 32'(pushed), 32'd1);
        n0 = cyc;
        for (int i = 0; i < 8; i++) begin
            idle_cycles(1);
            if (cyc == n0 + 2) check("single_A", out_dataA, 32'h0006ABCD);
            if (cyc == n0 + 3) check("single_B", out_dataB, 32'hC0000005);
            if (cyc == n0 + 4) check("single_busy_gap", 32'(busy), 32'd1);
            if (cyc == n0 + 5) check("single_busy_off", 32'(busy), 32'd0);
        end

        // Strobe override of b[30]
        run_cycle(1'b1, 18'h00001, 32'h00000001, pushed);
        n0 = cyc;
        for (int i = 0; i < 6; i++) begin
            idle_cycles(1);
            if (cyc == n0 + 3) begin
                check("ovr_B", out_dataB, 32'h40000001);
                check("ovr_A_low", out_dataA, 32'd0);
            end
        end

        // Fill and back-pressure: six pairs with in_valid held high
        for (int i = 0; i < 6; i++) begin
            fa[i] = 18'(32'h100 + i);
            fb[i] = 32'hA0000000 | 32'(i);
        end
        k = 0;
        saw_not_ready = 1'b0;
        sa_times.delete();
        for (int i = 0; i < 60; i++) begin
            if (k < 6) begin
                if (!in_ready) saw_not_ready = 1'b1;
                run_cycle(1'b1, fa[k], fb[k], pushed);
                if (pushed) k++;
            end else begin
                idle_cycles(1);
            end
            if (out_dataA[18]) sa_times.push_back(cyc);
        end
        check("fill_all_pushed", 32'(k), 32'd6);
        check("fill_backpressure", 32'(saw_not_ready), 32'd1);
        check("fill_strobe_count", 32'(sa_times.size()), 32'd6);
        for (int i = 1; i < sa_times.size(); i++) begin
            check("fill_spacing", 32'(sa_times[i] - sa_times[i-1]), 32'(2 + GAP));
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            run_cycle(($urandom_range(0, 3) != 0), 18'($urandom), $urandom, pushed);
        end
        idle_cycles(40);
        check("drain_level", 32'(level), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        // Reset during SEND_B output
        run_cycle(1'b1, 18'h3FFFF, 32'h12345678, pushed);
        run_cycle(1'b1, 18'h15555, 32'h87654321, pushed);
        for (int i = 0; i < 10; i++) begin
            if (!exp_b.exists(cyc)) idle_cycles(1);
        end
        check("rstB_strobe_pre", 32'(out_dataB[30]), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rstB_dataA", out_dataA, 32'd0);
        check("rstB_dataB", out_dataB, 32'd0);
        check("rstB_level", 32'(level), 32'd0);
        check("rstB_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle_cycles(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
